// File: rtl/havalimani_pkg.sv
// Shared types, reject codes and the passenger-ID validity helper for the
// boarding-gate check-in block.
package havalimani_pkg;

  // Gate controller states.
  typedef enum logic [1:0] {
    BOS    = 2'd0,
    HESAP  = 2'd1,
    SONUC  = 2'd2,
    KALKIS = 2'd3
  } durum_t;

  // Reject reasons, listed from highest to lowest priority.
  localparam logic [1:0] RED_KIMLIK = 2'd0;
  localparam logic [1:0] RED_TEKRAR = 2'd1;
  localparam logic [1:0] RED_BAKIYE = 2'd2;
  localparam logic [1:0] RED_YUK    = 2'd3;

  // An ID is valid when it is non-zero and has an even number of set bits.
  // Callers zero-extend their ID to 32 bits; this does not change the popcount.
  function automatic logic kimlik_gecerli(input logic [31:0] no);
    return (no != 32'd0) && !(^no);
  endfunction

endpackage

// File: rtl/havalimani_kapi_yolcu_listesi.sv
// Flight manifest: one ID register plus an occupied bit per seat. New IDs go
// into the lowest free slot, and lookups compare against every slot at once.
module yolcu_listesi #(
  parameter int BIT    = 6,
  parameter int KOLTUK = 4
) (
  input  logic           saat,
  input  logic           reset,
  input  logic           ekle,
  input  logic           temizle,
  input  logic [BIT-1:0] yeni_no,
  input  logic [BIT-1:0] sorgu_no,
  output logic           var_mi
);

  logic [BIT-1:0]    kayit_r [KOLTUK];
  logic [KOLTUK-1:0] dolu_r;
  logic [KOLTUK-1:0] yaz_s;
  logic              bos_bulundu_s;

  // Pick the lowest free slot as the write target for an insert.
  always_comb begin
    yaz_s         = '0;
    bos_bulundu_s = 1'b0;
    for (int i = 0; i < KOLTUK; i++) begin
      if (!dolu_r[i] && !bos_bulundu_s) begin
        yaz_s[i]      = ekle;
        bos_bulundu_s = 1'b1;
      end else begin
        yaz_s[i] = 1'b0;
      end
    end
  end

  // Parallel compare of the query ID against all occupied slots.
  always_comb begin
    var_mi = 1'b0;
    for (int i = 0; i < KOLTUK; i++) begin
      if (dolu_r[i] && (kayit_r[i] == sorgu_no)) begin
        var_mi = 1'b1;
      end else begin
        var_mi = var_mi;
      end
    end
  end

  // Manifest storage: clearing takes priority over an insert.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      dolu_r <= '0;
      for (int i = 0; i < KOLTUK; i++) begin
        kayit_r[i] <= '0;
      end
    end else if (temizle) begin
      dolu_r <= '0;
    end else begin
      for (int i = 0; i < KOLTUK; i++) begin
        if (yaz_s[i]) begin
          kayit_r[i] <= yeni_no;
          dolu_r[i]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/havalimani_kapi.sv
// Boarding-gate check-in: takes passengers over valid/ready, prices the ticket
// and excess baggage, checks the ID, the manifest, the balance and the load
// limit, and then closes the flight with a one-cycle kalkis pulse.
module havalimani_kapi
  import havalimani_pkg::*;
#(
  parameter int BIT           = 6,
  parameter int KOLTUK        = 4,
  parameter int YUK_LIMIT     = 200,
  parameter int YERLI_UCRET   = 45,
  parameter int YABANCI_UCRET = 90,
  parameter int SERBEST       = 20,
  parameter int KG_UCRET      = 2,
  parameter int BEKLEME       = 64
) (
  input  logic                          saat,
  input  logic                          reset,
  input  logic                          giris_gecerli,
  output logic                          giris_hazir,
  input  logic [BIT-1:0]                kimlik_no,
  input  logic                          uyruk,
  input  logic [5:0]                    agirlik,
  input  logic [8:0]                    bakiye,
  output logic                          sonuc_gecerli,
  output logic                          kabul,
  output logic [1:0]                    red_kodu,
  output logic [8:0]                    k_bakiye,
  output logic [$clog2(KOLTUK+1)-1:0]   yolcu_sayisi,
  output logic [9:0]                    toplam_yuk,
  output logic                          kalkis
);

  localparam int SW = $clog2(KOLTUK + 1);
  localparam int CW = $clog2(BEKLEME);
  localparam logic [SW-1:0] KOLTUK_W   = SW'(KOLTUK);
  localparam logic [9:0]    LIMIT_W    = 10'(YUK_LIMIT);
  localparam logic [CW-1:0] BEKLE_SON  = CW'(BEKLEME - 1);

  durum_t         durum_r, durum_next_s;
  logic [BIT-1:0] kimlik_r;
  logic           uyruk_r;
  logic [5:0]     agirlik_r;
  logic [8:0]     bakiye_r;
  logic           karar_kabul_r;
  logic [1:0]     karar_red_r;
  logic [8:0]     karar_bakiye_r;
  logic [SW-1:0]  yolcu_r;
  logic [9:0]     toplam_r;
  logic [CW-1:0]  bekle_r;
  logic           giris_hazir_r, sonuc_gecerli_r, kabul_r, kalkis_r;
  logic [1:0]     red_kodu_r;
  logic [8:0]     k_bakiye_r;

  logic           el_sikisma_s, var_mi_s, kabul_s;
  logic [1:0]     red_s;
  logic [9:0]     fazla_kg_s, ucret_s;
  logic           cikis_hazir_s, cikis_sonuc_s, cikis_kalkis_s;

  assign el_sikisma_s = giris_gecerli && (durum_r == BOS);

  yolcu_listesi #(.BIT(BIT), .KOLTUK(KOLTUK)) u_liste (
    .saat     (saat),
    .reset    (reset),
    .ekle     ((durum_r == HESAP) && kabul_s),
    .temizle  (durum_r == KALKIS),
    .yeni_no  (kimlik_r),
    .sorgu_no (kimlik_r),
    .var_mi   (var_mi_s)
  );

  // Pricing and verdict for the registered passenger, in 10/11-bit arithmetic.
  always_comb begin
    fazla_kg_s = 10'd0;
    if (10'(agirlik_r) > 10'(SERBEST)) begin
      fazla_kg_s = 10'(agirlik_r) - 10'(SERBEST);
    end else begin
      fazla_kg_s = 10'd0;
    end
    ucret_s = (uyruk_r ? 10'(YABANCI_UCRET) : 10'(YERLI_UCRET)) + fazla_kg_s * 10'(KG_UCRET);
    kabul_s = 1'b0;
    red_s   = RED_KIMLIK;
    if (!kimlik_gecerli(32'(kimlik_r))) begin
      red_s = RED_KIMLIK;
    end else if (var_mi_s) begin
      red_s = RED_TEKRAR;
    end else if ({1'b0, bakiye_r} < ucret_s) begin
      red_s = RED_BAKIYE;
    end else if ((11'(toplam_r) + 11'(agirlik_r)) > 11'(YUK_LIMIT)) begin
      red_s = RED_YUK;
    end else begin
      kabul_s = 1'b1;
      red_s   = RED_KIMLIK;
    end
  end

  // State register.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_r <= BOS;
    end else begin
      durum_r <= durum_next_s;
    end
  end

  // Next-state logic; a handshake wins over an expiring idle timer.
  always_comb begin
    durum_next_s = durum_r;
    case (durum_r)
      BOS: begin
        if (giris_gecerli) begin
          durum_next_s = HESAP;
        end else if ((yolcu_r != '0) && (bekle_r == BEKLE_SON)) begin
          durum_next_s = KALKIS;
        end else begin
          durum_next_s = BOS;
        end
      end
      HESAP:  durum_next_s = SONUC;
      SONUC: begin
        if (karar_kabul_r && ((yolcu_r == KOLTUK_W) || (toplam_r == LIMIT_W))) begin
          durum_next_s = KALKIS;
        end else begin
          durum_next_s = BOS;
        end
      end
      KALKIS:  durum_next_s = BOS;
      default: durum_next_s = BOS;
    endcase
  end

  // Input capture, verdict latch, flight counters and idle timer.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      kimlik_r       <= '0;
      uyruk_r        <= 1'b0;
      agirlik_r      <= 6'd0;
      bakiye_r       <= 9'd0;
      karar_kabul_r  <= 1'b0;
      karar_red_r    <= 2'd0;
      karar_bakiye_r <= 9'd0;
      yolcu_r        <= '0;
      toplam_r       <= 10'd0;
      bekle_r        <= '0;
    end else begin
      case (durum_r)
        BOS: begin
          if (el_sikisma_s) begin
            kimlik_r  <= kimlik_no;
            uyruk_r   <= uyruk;
            agirlik_r <= agirlik;
            bakiye_r  <= bakiye;
            bekle_r   <= '0;
          end else if ((yolcu_r != '0) && (bekle_r != BEKLE_SON)) begin
            bekle_r <= bekle_r + CW'(1);
          end
        end
        HESAP: begin
          karar_kabul_r  <= kabul_s;
          karar_red_r    <= red_s;
          karar_bakiye_r <= kabul_s ? (bakiye_r - ucret_s[8:0]) : bakiye_r;
          if (kabul_s) begin
            yolcu_r  <= yolcu_r + SW'(1);
            toplam_r <= toplam_r + 10'(agirlik_r);
          end
        end
        KALKIS: begin
          yolcu_r  <= '0;
          toplam_r <= 10'd0;
          bekle_r  <= '0;
        end
        default: begin
          bekle_r <= bekle_r;
        end
      endcase
    end
  end

  // Output decode: what the registered outputs become after the next edge.
  always_comb begin
    cikis_hazir_s  = 1'b0;
    cikis_sonuc_s  = 1'b0;
    cikis_kalkis_s = 1'b0;
    case (durum_r)
      SONUC:   cikis_sonuc_s  = 1'b1;
      KALKIS:  cikis_kalkis_s = 1'b1;
      default: cikis_sonuc_s  = 1'b0;
    endcase
    cikis_hazir_s = (durum_next_s == BOS);
  end

  // Registered outputs; the verdict fields hold until the next result.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      giris_hazir_r   <= 1'b1;
      sonuc_gecerli_r <= 1'b0;
      kalkis_r        <= 1'b0;
      kabul_r         <= 1'b0;
      red_kodu_r      <= 2'd0;
      k_bakiye_r      <= 9'd0;
    end else begin
      giris_hazir_r   <= cikis_hazir_s;
      sonuc_gecerli_r <= cikis_sonuc_s;
      kalkis_r        <= cikis_kalkis_s;
      if (cikis_sonuc_s) begin
        kabul_r    <= karar_kabul_r;
        red_kodu_r <= karar_red_r;
        k_bakiye_r <= karar_bakiye_r;
      end
    end
  end

  assign giris_hazir   = giris_hazir_r;
  assign sonuc_gecerli = sonuc_gecerli_r;
  assign kalkis        = kalkis_r;
  assign kabul         = kabul_r;
  assign red_kodu      = red_kodu_r;
  assign k_bakiye      = k_bakiye_r;
  assign yolcu_sayisi  = yolcu_r;
  assign toplam_yuk    = toplam_r;

endmodule

// File: tb/tb_havalimani_kapi.sv
// Directed bench for havalimani_kapi with hand-computed expected values.
module tb_havalimani_kapi;

  logic       saat = 1'b0;
  logic       reset;
  logic       giris_gecerli;
  logic       giris_hazir;
  logic [5:0] kimlik_no;
  logic       uyruk;
  logic [5:0] agirlik;
  logic [8:0] bakiye;
  logic       sonuc_gecerli;
  logic       kabul;
  logic [1:0] red_kodu;
  logic [8:0] k_bakiye;
  logic [2:0] yolcu_sayisi;
  logic [9:0] toplam_yuk;
  logic       kalkis;

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;

  // Values captured around each result strobe.
  int         lat_k;
  logic       kabul_k;
  logic [1:0] red_k;
  logic [8:0] bak_k;
  logic [2:0] yolcu_k;
  logic [9:0] yuk_k;
  logic       kalkis_k;
  logic [2:0] yolcu_sonra;
  logic [9:0] yuk_sonra;

  havalimani_kapi dut (
    .saat          (saat),
    .reset         (reset),
    .giris_gecerli (giris_gecerli),
    .giris_hazir   (giris_hazir),
    .kimlik_no     (kimlik_no),
    .uyruk         (uyruk),
    .agirlik       (agirlik),
    .bakiye        (bakiye),
    .sonuc_gecerli (sonuc_gecerli),
    .kabul         (kabul),
    .red_kodu      (red_kodu),
    .k_bakiye      (k_bakiye),
    .yolcu_sayisi  (yolcu_sayisi),
    .toplam_yuk    (toplam_yuk),
    .kalkis        (kalkis)
  );

  always #5 saat = ~saat;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: observed=%0d expected=%0d", etiket, gozlenen, beklenen);
    end
  endtask

  // Wait for ready, then present one passenger for a single handshake edge.
  task automatic gonder(input logic [5:0] k, input logic u, input logic [5:0] a, input logic [8:0] b);
    bit hazir = 1'b0;
    for (int i = 0; i < 20 && !hazir; i++) begin
      @(negedge saat);
      hazir = giris_hazir;
    end
    kontrol("hazir_bekle", 32'(hazir), 32'd1);
    kimlik_no = k; uyruk = u; agirlik = a; bakiye = b;
    giris_gecerli = 1'b1;
    @(posedge saat);
    #1 giris_gecerli = 1'b0;
  endtask

  // Find the result strobe (latency in cycles after the handshake edge) and
  // look at the cycle after it for kalkis.
  task automatic sonuc_bekle();
    bit bulundu = 1'b0;
    lat_k = 99;
    for (int n = 0; n < 10 && !bulundu; n++) begin
      @(negedge saat);
      if (sonuc_gecerli) begin
        bulundu = 1'b1;
        lat_k   = n;
        kabul_k = kabul; red_k = red_kodu; bak_k = k_bakiye;
        yolcu_k = yolcu_sayisi; yuk_k = toplam_yuk;
      end
    end
    @(negedge saat);
    kalkis_k    = kalkis;
    yolcu_sonra = yolcu_sayisi;
    yuk_sonra   = toplam_yuk;
  endtask

  task automatic yolcu(input string ad, input logic [5:0] k, input logic u, input logic [5:0] a,
                       input logic [8:0] b, input logic e_kab, input logic [1:0] e_red,
                       input logic [8:0] e_bak, input logic [2:0] e_yol, input logic [9:0] e_yuk,
                       input logic e_kalk);
    gonder(k, u, a, b);
    sonuc_bekle();
    kontrol({ad, "_gecikme"}, 32'(lat_k), 32'd2);
    kontrol({ad, "_kabul"}, 32'(kabul_k), 32'(e_kab));
    kontrol({ad, "_red"}, 32'(red_k), 32'(e_red));
    kontrol({ad, "_kbakiye"}, 32'(bak_k), 32'(e_bak));
    kontrol({ad, "_yolcu"}, 32'(yolcu_k), 32'(e_yol));
    kontrol({ad, "_yuk"}, 32'(yuk_k), 32'(e_yuk));
    kontrol({ad, "_kalkis"}, 32'(kalkis_k), 32'(e_kalk));
  endtask

  initial begin
    int pulses;
    int ilk;
    reset = 1'b0; giris_gecerli = 1'b0;
    kimlik_no = 6'd0; uyruk = 1'b0; agirlik = 6'd0; bakiye = 9'd0;
    repeat (3) @(negedge saat);
    kontrol("rst_hazir", 32'(giris_hazir), 32'd1);
    kontrol("rst_sonuc", 32'(sonuc_gecerli), 32'd0);
    kontrol("rst_kalkis", 32'(kalkis), 32'd0);
    kontrol("rst_kbakiye", 32'(k_bakiye), 32'd0);
    kontrol("rst_yolcu", 32'(yolcu_sayisi), 32'd0);
    reset = 1'b1;

    // ucret = 45 + 10*2 = 65
    yolcu("yerli", 6'b000011, 1'b0, 6'd30, 9'd100, 1'b1, 2'd0, 9'd35, 3'd1, 10'd30, 1'b0);
    // popcount 3 -> invalid
    yolcu("kimlik", 6'b000111, 1'b0, 6'd10, 9'd50, 1'b0, 2'd0, 9'd50, 3'd1, 10'd30, 1'b0);
    yolcu("tekrar", 6'b000011, 1'b0, 6'd5, 9'd100, 1'b0, 2'd1, 9'd100, 3'd1, 10'd30, 1'b0);
    // foreign, 14 kg -> ucret 90
    yolcu("bakiye_az", 6'b110011, 1'b1, 6'd14, 9'd80, 1'b0, 2'd2, 9'd80, 3'd1, 10'd30, 1'b0);
    yolcu("bakiye_ok", 6'b110011, 1'b1, 6'd14, 9'd100, 1'b1, 2'd0, 9'd10, 3'd2, 10'd44, 1'b0);
    // balance exactly equal to ucret
    yolcu("koltuk3", 6'b000101, 1'b0, 6'd0, 9'd45, 1'b1, 2'd0, 9'd0, 3'd3, 10'd44, 1'b0);
    yolcu("koltuk4", 6'b001001, 1'b0, 6'd0, 9'd50, 1'b1, 2'd0, 9'd5, 3'd4, 10'd44, 1'b1);
    kontrol("dolu_sonra_yolcu", 32'(yolcu_sonra), 32'd0);
    kontrol("dolu_sonra_yuk", 32'(yuk_sonra), 32'd0);

    // New flight: 000011 reusable. 50 kg -> ucret 45 + 60 = 105
    yolcu("yeni_ucus", 6'b000011, 1'b0, 6'd50, 9'd200, 1'b1, 2'd0, 9'd95, 3'd1, 10'd50, 1'b0);
    yolcu("yuk2", 6'b000101, 1'b0, 6'd50, 9'd200, 1'b1, 2'd0, 9'd95, 3'd2, 10'd100, 1'b0);
    yolcu("yuk3", 6'b001001, 1'b0, 6'd50, 9'd200, 1'b1, 2'd0, 9'd95, 3'd3, 10'd150, 1'b0);
    // 60 kg -> ucret 125, load 210 > 200
    yolcu("yuk_asim", 6'b001010, 1'b0, 6'd60, 9'd300, 1'b0, 2'd3, 9'd300, 3'd3, 10'd150, 1'b0);
    yolcu("yuk_tam", 6'b001100, 1'b0, 6'd50, 9'd200, 1'b1, 2'd0, 9'd95, 3'd4, 10'd200, 1'b1);
    kontrol("yuk_sonra", 32'(yuk_sonra), 32'd0);

    // Empty flight never times out.
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge saat);
      if (kalkis) pulses++;
    end
    kontrol("bos_bekleme", 32'(pulses), 32'd0);

    // One passenger, then idle: kalkis 65 cycles after the result strobe.
    yolcu("bekleme", 6'b000011, 1'b0, 6'd0, 9'd45, 1'b1, 2'd0, 9'd0, 3'd1, 10'd0, 1'b0);
    pulses = 0; ilk = 0;
    for (int k = 2; k < 120; k++) begin
      @(negedge saat);
      if (kalkis) begin
        pulses++;
        if (ilk == 0) ilk = k;
      end
    end
    kontrol("zaman_asimi_sayi", 32'(pulses), 32'd1);
    kontrol("zaman_asimi_an", 32'(ilk), 32'd65);
    kontrol("zaman_asimi_yolcu", 32'(yolcu_sayisi), 32'd0);

    // Reset in HESAP aborts the passenger and clears the manifest.
    yolcu("rst_once", 6'b000011, 1'b0, 6'd30, 9'd100, 1'b1, 2'd0, 9'd35, 3'd1, 10'd30, 1'b0);
    gonder(6'b000101, 1'b0, 6'd10, 9'd100);
    #2 reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge saat);
      if (sonuc_gecerli || kalkis) pulses++;
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge saat);
      if (sonuc_gecerli || kalkis) pulses++;
    end
    kontrol("rst_iptal_darbe", 32'(pulses), 32'd0);
    kontrol("rst_iptal_hazir", 32'(giris_hazir), 32'd1);
    kontrol("rst_iptal_kabul", 32'(kabul), 32'd0);
    kontrol("rst_iptal_kbakiye", 32'(k_bakiye), 32'd0);
    kontrol("rst_iptal_yolcu", 32'(yolcu_sayisi), 32'd0);
    kontrol("rst_iptal_yuk", 32'(toplam_yuk), 32'd0);
    yolcu("rst_sonra", 6'b000011, 1'b0, 6'd30, 9'd100, 1'b1, 2'd0, 9'd35, 3'd1, 10'd30, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
